// File: rtl/aer_event_receiver_if.sv
// Event stream interface of the AER event receiver.
// master = receiver side (drives valid/data), slave = readout/packetizer side.
interface aer_event_receiver_if #(
    parameter int DW = 5
);
    logic          evt_valid_o;
    logic [DW-1:0] evt_data_o;
    logic          evt_ready_i;

    modport master (
        output evt_valid_o,
        output evt_data_o,
        input  evt_ready_i
    );

    modport slave (
        input  evt_valid_o,
        input  evt_data_o,
        output evt_ready_i
    );
endinterface

// File: rtl/aer_event_receiver.sv
// AER event receiver: turns pixel-arbiter grants into event words and group
// releases into marker words, buffered in a first-word-fall-through FIFO and
// drained over a valid/ready stream.
// Optional feature macro: EVT_TIMESTAMP_EN adds a TS_W-bit timestamp field
// to every word. Without it no counter is built and words are {type, x, y}.
module aer_event_receiver #(
    parameter int X_W   = 2,
    parameter int Y_W   = 2,
    parameter int TS_W  = 16,
    parameter int DEPTH = 8
) (
    input  logic                       clk_i,
    input  logic                       reset_ni,
    input  logic                       enable_i,
    input  logic                       active_i,
    input  logic [X_W-1:0]             x_add_i,
    input  logic [Y_W-1:0]             y_add_i,
    input  logic                       grp_release_i,
    input  logic                       clear_i,
    aer_event_receiver_if.master       evt_if,
    output logic [$clog2(DEPTH):0]     fifo_level_o,
    output logic                       overflow_o,
    output logic [7:0]                 drop_count_o
);

`ifdef EVT_TIMESTAMP_EN
    localparam int TS_FW = TS_W;
`else
    // The timestamp field collapses to zero width when the counter is not built.
    localparam int TS_FW = TS_W * 0;
`endif
    localparam int AW = $clog2(DEPTH);
    localparam int AD = X_W + Y_W;
    localparam int DW = 1 + TS_FW + AD;

    // Input tracking state
    logic [AD-1:0]  r_last_addr;
    logic           r_active_q;
    logic           r_grp_q;
    logic           r_marker_pend;

    // FIFO state
    logic [DW-1:0]  r_mem [DEPTH];
    logic [AW:0]    r_wr_ptr;
    logic [AW:0]    r_rd_ptr;
    logic           r_overflow;
    logic [7:0]     r_drop_count;

    logic [AD-1:0]  w_addr;
    logic           w_ev;
    logic           w_mk;
    logic           w_marker_any;
    logic [DW-1:0]  w_evt_word;
    logic [DW-1:0]  w_mark_word;
    logic           w_push;
    logic [DW-1:0]  w_push_word;
    logic           w_pend_next;
    logic [AW:0]    w_level;
    logic           w_empty;
    logic           w_full;
    logic           w_pop;
    logic           w_wr_en;
    logic           w_drop;

    assign w_addr = {x_add_i, y_add_i};

    // A grant is new when the arbiter just became active or moved to another pixel.
    assign w_ev = enable_i & active_i & (~r_active_q | (w_addr != r_last_addr));
    assign w_mk = enable_i & grp_release_i & ~r_grp_q;
    assign w_marker_any = w_mk | r_marker_pend;

`ifdef EVT_TIMESTAMP_EN
    logic [TS_W-1:0] r_ts;

    // Free-running timestamp, frozen while capture is disabled; wraps naturally.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset_ni) begin
            r_ts <= '0;
        end else if (enable_i) begin
            r_ts <= r_ts + 1'b1;
        end
    end

    assign w_evt_word  = {1'b0, r_ts, w_addr};
    assign w_mark_word = {1'b1, r_ts, {AD{1'b0}}};
`else
    assign w_evt_word  = {1'b0, w_addr};
    assign w_mark_word = {1'b1, {AD{1'b0}}};
`endif

    // Push arbitration: an event always wins; a colliding marker waits one slot.
    always_comb begin
        // NOTE: defaults first so a path that assigns nothing cannot infer a latch.
        w_push      = 1'b0;
        w_push_word = '0;
        w_pend_next = r_marker_pend;
        if (w_ev) begin
            w_push      = 1'b1;
            w_push_word = w_evt_word;
            w_pend_next = w_marker_any;
        end else if (w_marker_any) begin
            w_push      = 1'b1;
            w_push_word = w_mark_word;
            w_pend_next = 1'b0;
        end
    end

    assign w_level = r_wr_ptr - r_rd_ptr;
    assign w_empty = (w_level == '0);
    assign w_full  = (w_level == (AW+1)'(DEPTH));
    assign w_pop   = ~w_empty & evt_if.evt_ready_i;
    // When full, a simultaneous pop frees the slot the push needs.
    assign w_wr_en = w_push & (~w_full | w_pop);
    assign w_drop  = w_push & w_full & ~w_pop;

    // Edge detectors and address history; cleared while disabled so re-enable re-arms.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_last_addr   <= '0;
            r_active_q    <= 1'b0;
            r_grp_q       <= 1'b0;
            r_marker_pend <= 1'b0;
        end else begin
            r_marker_pend <= w_pend_next;
            if (enable_i) begin
                r_last_addr <= w_addr;
                r_active_q  <= active_i;
                r_grp_q     <= grp_release_i;
            end else begin
                r_active_q  <= 1'b0;
                r_grp_q     <= 1'b0;
            end
        end
    end

    // FIFO pointers; extra MSB distinguishes full from empty.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // FIFO storage write.
    always_ff @(posedge clk_i) begin
        // NOTE: storage is deliberately not reset; pointers define validity and the output is masked when empty.
        if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= w_push_word;
    end

    // Sticky overflow and saturating drop counter; a same-cycle drop beats clear.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (clear_i) begin
                r_drop_count <= 8'd1;
            end else if (r_drop_count != 8'hFF) begin
                r_drop_count <= r_drop_count + 8'd1;
            end
        end else if (clear_i) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end
    end

    assign evt_if.evt_valid_o = ~w_empty;
    assign evt_if.evt_data_o  = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
    assign fifo_level_o       = w_level;
    assign overflow_o         = r_overflow;
    assign drop_count_o       = r_drop_count;

endmodule
